// File: rtl/sram_access_ctrl_if.sv
// Request/response bus between a requester and the SRAM access controller.
// The requester drives the request half; the controller drives ready and the response.
interface sram_access_ctrl_if #(
    parameter int AW   = 4,
    parameter int COLS = 8
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [AW-1:0]   req_addr;
    logic [COLS-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_err;
    logic [COLS-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// Sequences one SRAM row access (precharge, decode, word-line, write or sense) per request,
// driving the array-facing controls as VDD/VSS levels and answering on a one-cycle response.
module sram_access_ctrl #(
    parameter int ROWS  = 16,
    parameter int COLS  = 8,
    parameter int T_PRE = 2,
    parameter int T_WL  = 2,
    parameter int T_SA  = 1,
    localparam int AW   = $clog2(ROWS)
) (
    input  logic clk,
    input  logic rst,
    sram_access_ctrl_if.slave bus,
    output real  row_sel  [0:AW-1],
    output real  pre_en,
    output real  wl_en,
    output real  wr_en,
    output real  sa_en,
    output real  bl_wdata [0:COLS-1],
    input  real  bl_sense [0:COLS-1]
);
    localparam real VDD = 1.5;
    localparam real VSS = 0.0;
    localparam real VTH = 0.8;

    localparam int T_MAX = (T_PRE > T_WL) ? ((T_PRE > T_SA) ? T_PRE : T_SA)
                                          : ((T_WL  > T_SA) ? T_WL  : T_SA);
    localparam int CW    = (T_MAX > 1) ? $clog2(T_MAX + 1) : 1;
    localparam logic [AW:0] ERR_ADDR = (AW+1)'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DEC,
        WL,
        SA,
        RSP
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            we_q;
    logic [AW-1:0]   addr_q;
    logic [COLS-1:0] wdata_q;
    logic            err_pend;

    logic            pre_q;
    logic            wl_q;
    logic            wr_q;
    logic            sa_q;
    logic [AW-1:0]   row_q;
    logic [COLS-1:0] wd_q;
    logic [COLS-1:0] sense_bits;

    always_comb begin
        // NOTE: default first so no path leaves the variable unassigned (no latch).
        sense_bits = '0;
        for (int i = 0; i < COLS; i++) begin
            sense_bits[i] = (bl_sense[i] >= VTH);
        end
    end

    // Outputs are registered: each transition loads the values of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking everywhere here, so every register sees pre-edge values.
            state         <= IDLE;
            cnt           <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            err_pend      <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            pre_q         <= 1'b0;
            wl_q          <= 1'b0;
            wr_q          <= 1'b0;
            sa_q          <= 1'b0;
            row_q         <= '0;
            wd_q          <= '0;
        end else begin
            bus.rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    // An out-of-range request never touches the array; it answers one cycle after accept.
                    if (err_pend) begin
                        err_pend      <= 1'b0;
                        state         <= RSP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                    end else if (bus.req_valid && bus.req_ready) begin
                        we_q          <= bus.req_we;
                        addr_q        <= bus.req_addr;
                        wdata_q       <= bus.req_wdata;
                        bus.req_ready <= 1'b0;
                        if ({1'b0, bus.req_addr} >= ERR_ADDR) begin
                            err_pend <= 1'b1;
                        end else begin
                            state <= PRE;
                            cnt   <= CW'(T_PRE - 1);
                            pre_q <= 1'b1;
                        end
                    end
                end
                PRE: begin
                    if (cnt == '0) begin
                        state <= DEC;
                        pre_q <= 1'b0;
                        row_q <= addr_q + AW'(1);
                        if (we_q) wd_q <= wdata_q;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DEC: begin
                    state <= WL;
                    cnt   <= CW'(T_WL - 1);
                    wl_q  <= 1'b1;
                    wr_q  <= we_q;
                end
                WL: begin
                    if (cnt == '0) begin
                        wr_q <= 1'b0;
                        if (we_q) begin
                            state         <= RSP;
                            wl_q          <= 1'b0;
                            row_q         <= '0;
                            wd_q          <= '0;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= 1'b0;
                        end else begin
                            state <= SA;
                            cnt   <= CW'(T_SA - 1);
                            sa_q  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                SA: begin
                    if (cnt == '0) begin
                        state         <= RSP;
                        wl_q          <= 1'b0;
                        sa_q          <= 1'b0;
                        row_q         <= '0;
                        bus.rsp_rdata <= sense_bits;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RSP: begin
                    state         <= IDLE;
                    bus.req_ready <= 1'b1;
                    bus.rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pre_en = pre_q ? VDD : VSS;
    assign wl_en  = wl_q  ? VDD : VSS;
    assign wr_en  = wr_q  ? VDD : VSS;
    assign sa_en  = sa_q  ? VDD : VSS;

    for (genvar i = 0; i < AW; i++) begin : g_row
        assign row_sel[i] = row_q[i] ? VDD : VSS;
    end

    for (genvar i = 0; i < COLS; i++) begin : g_bl
        assign bl_wdata[i] = wd_q[i] ? VDD : VSS;
    end
endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: a driver queues expected transactions, a monitor checks every
// cycle against a timeline model and pops the scoreboard on each response.
module tb_sram_access_ctrl;
    localparam int  ROWS  = 16;
    localparam int  COLS  = 8;
    localparam int  AW    = 4;
    localparam int  T_PRE = 2;
    localparam int  T_WL  = 2;
    localparam int  T_SA  = 1;
    localparam real VDD   = 1.5;
    localparam real VSS   = 0.0;
    localparam int  W     = 8 + AW + 2 * COLS;

    typedef struct {
        int              e0;
        bit              we;
        int              addr;
        logic [COLS-1:0] wdata;
        bit              err;
        logic [COLS-1:0] rdata;
    } txn_t;

    logic clk;
    logic rst;
    real  row_sel  [0:AW-1];
    real  pre_en;
    real  wl_en;
    real  wr_en;
    real  sa_en;
    real  bl_wdata [0:COLS-1];
    real  bl_sense [0:COLS-1];
    real  next_lv  [0:COLS-1];
    real  lv_tab   [0:5];

    int   n_checks;
    int   n_fail;
    int   cyc;
    bit   rst_at_edge;
    txn_t sb[$];
    logic [COLS-1:0] model_rdata;

    sram_access_ctrl_if #(.AW(AW), .COLS(COLS)) bus ();

    sram_access_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .T_PRE(T_PRE), .T_WL(T_WL), .T_SA(T_SA)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .row_sel(row_sel),
        .pre_en(pre_en),
        .wl_en(wl_en),
        .wr_en(wr_en),
        .sa_en(sa_en),
        .bl_wdata(bl_wdata),
        .bl_sense(bl_sense)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit lvl(input real v);
        return v == VDD;
    endfunction

    function automatic bit lvl_bad(input real v);
        return (v != VDD) && (v != VSS);
    endfunction

    // Observed cycle state: {ready, rsp_valid, rsp_err, pre, wl, wr, sa, bad_level, row, wdata, rdata}
    function automatic logic [W-1:0] observe();
        logic [AW-1:0]   r;
        logic [COLS-1:0] d;
        bit              bad;
        bad = lvl_bad(pre_en) || lvl_bad(wl_en) || lvl_bad(wr_en) || lvl_bad(sa_en);
        for (int i = 0; i < AW; i++) begin
            r[i] = lvl(row_sel[i]);
            bad  = bad || lvl_bad(row_sel[i]);
        end
        for (int i = 0; i < COLS; i++) begin
            d[i] = lvl(bl_wdata[i]);
            bad  = bad || lvl_bad(bl_wdata[i]);
        end
        return {bus.req_ready, bus.rsp_valid, bus.rsp_err, lvl(pre_en), lvl(wl_en),
                lvl(wr_en), lvl(sa_en), bad, r, d, bus.rsp_rdata};
    endfunction

    initial begin : monitor
        txn_t            t;
        int              o;
        int              lat;
        bit              rdy, rv, re, pre, wl, wr, sa;
        logic [AW-1:0]   row;
        logic [COLS-1:0] wd;
        logic [W-1:0]    exp_v;
        forever begin
            @(negedge clk);
            rdy = 1'b1; rv = 1'b0; re = 1'b0; pre = 1'b0; wl = 1'b0; wr = 1'b0; sa = 1'b0;
            row = '0;   wd = '0;
            if (rst_at_edge) begin
                sb.delete();
                model_rdata = '0;
            end else if (sb.size() > 0 && cyc >= sb[0].e0) begin
                t   = sb[0];
                o   = cyc - t.e0;
                lat = t.err ? 1 : (t.we ? T_PRE + T_WL + 1 : T_PRE + T_WL + T_SA + 1);
                rdy = 1'b0;
                if (!t.err) begin
                    pre = o < T_PRE;
                    wl  = (o >= T_PRE + 1) && (o < lat);
                    wr  = t.we && wl;
                    sa  = !t.we && (o >= T_PRE + 1 + T_WL) && (o < lat);
                    if (o >= T_PRE && o < lat) begin
                        row = AW'(t.addr + 1);
                        if (t.we) wd = t.wdata;
                    end
                end
                if (o == lat) begin
                    rv = 1'b1;
                    re = t.err;
                    if (!t.err && !t.we) model_rdata = t.rdata;
                    void'(sb.pop_front());
                end
            end
            exp_v = {rdy, rv, re, pre, wl, wr, sa, 1'b0, row, wd, model_rdata};
            check($sformatf("cycle_state@%0d", cyc), 64'(observe()), 64'(exp_v));
            check($sformatf("pre_wl_overlap@%0d", cyc),
                  64'(pre_en == VDD && wl_en == VDD), 64'(0));
        end
    end

    function automatic logic [COLS-1:0] thresh();
        logic [COLS-1:0] b;
        for (int i = 0; i < COLS; i++) b[i] = next_lv[i] >= 0.8;
        return b;
    endfunction

    // Called on a negedge; returns on the negedge after the accepting edge.
    task automatic issue(input bit we, input int addr, input logic [COLS-1:0] wdata, input bit hold);
        txn_t t;
        int   n;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = AW'(addr);
        bus.req_wdata = wdata;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", 64'(0), 64'(1));
            bus.req_valid = 1'b0;
            return;
        end
        for (int i = 0; i < COLS; i++) bl_sense[i] = next_lv[i];
        t.e0    = cyc + 1;
        t.we    = we;
        t.addr  = addr;
        t.wdata = wdata;
        t.err   = addr >= ROWS - 1;
        t.rdata = thresh();
        sb.push_back(t);
        @(posedge clk);
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic set_pattern(input logic [COLS-1:0] p, input real hi, input real lo);
        for (int i = 0; i < COLS; i++) next_lv[i] = p[i] ? hi : lo;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) check("drain_timeout", 64'(sb.size()), 64'(0));
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        logic [COLS-1:0] pat;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        model_rdata = '0;
        lv_tab = '{0.0, 0.3, 0.79, 0.80, 1.2, 1.5};
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < COLS; i++) begin
            bl_sense[i] = VSS;
            next_lv[i]  = VSS;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        set_pattern(8'hA5, VDD, VSS);
        issue(1'b0, 5, 8'h00, 1'b0);
        drain();

        issue(1'b1, 3, 8'h3C, 1'b0);
        drain();

        issue(1'b0, 15, 8'h00, 1'b0);
        drain();

        // Reset lands while the word-line is up; the aborted read must not answer.
        set_pattern(8'h5A, VDD, VSS);
        issue(1'b0, 9, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        set_pattern(8'hC3, VDD, VSS);
        issue(1'b0, 2, 8'h00, 1'b0);
        drain();

        set_pattern(8'h69, 0.80, 0.79);
        issue(1'b0, 0, 8'h00, 1'b0);
        drain();

        // Back-to-back traffic with req_valid held high.
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < COLS; i++) next_lv[i] = lv_tab[$urandom_range(0, 5)];
            pat = COLS'($urandom);
            issue(1'($urandom_range(0, 1)), $urandom_range(0, ROWS - 1), pat, k != 23);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
